// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: forward S-box, rcon table,
// round/word counts and the key-schedule FSM state type.
package aes_pkg;

  localparam int unsigned NR     = 10;
  localparam int unsigned NK     = 4;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned RND_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_e;

  // Round key viewed as four 32-bit words, w0 in the top bits.
  typedef struct packed {
    logic [WORD_W-1:0] w0;
    logic [WORD_W-1:0] w1;
    logic [WORD_W-1:0] w2;
    logic [WORD_W-1:0] w3;
  } key_words_t;

  // Entry 0 is unused; rounds 1..10 index directly.
  localparam logic [7:0] RCON [NR+1] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/key_round_step.sv
// One forward AES-128 key-expansion step: RotWord, SubWord, rcon, XOR chain.
module key_round_step
  import aes_pkg::*;
(
  input  logic [127:0] prev_key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  key_words_t        p;
  key_words_t        n;
  logic [WORD_W-1:0] rot;
  logic [WORD_W-1:0] t;

  assign p = key_words_t'(prev_key);

  // Derive next round key from the previous one.
  always_comb begin
    rot  = {p.w3[23:0], p.w3[31:24]};
    t    = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
           ^ {rcon, 24'h0};
    n.w0 = p.w0 ^ t;
    n.w1 = p.w1 ^ n.w0;
    n.w2 = p.w2 ^ n.w1;
    n.w3 = p.w3 ^ n.w2;
  end

  assign next_key = 128'(n);

endmodule

// File: rtl/aes_128_dec_key_sched.sv
// AES-128 round-key generator for the decryption pipeline. Expands a cipher
// key one round per clock into an 11-entry register file with a registered
// read port. Optional zeroize input enabled by AES_KEY_ZEROIZE_EN.
module aes_128_dec_key_sched #(
  parameter int unsigned NR    = 10,
  parameter int unsigned KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic             keys_valid,
  input  logic [3:0]       rd_round,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic             zeroize,
`endif
  output logic [KEY_W-1:0] rd_key
);

  import aes_pkg::*;

  if (NR != 10 || KEY_W != 128) begin : g_param_chk
    $error("aes_128_dec_key_sched supports only NR=10 and KEY_W=128");
  end

  state_e           state_q, state_d;
  logic [RND_W-1:0] cnt_q, cnt_d;
  logic             key_ready_q, key_ready_d;
  logic             keys_valid_q, keys_valid_d;
  logic             load_key;
  logic             step_we;
  logic             clear_all;
  logic [RND_W-1:0] prev_idx;
  logic [KEY_W-1:0] step_key;
  logic [KEY_W-1:0] rk_q [NR+1];
  logic [KEY_W-1:0] rd_key_q, rd_key_d;

  // Previous key feeding the step; counter is 0 outside EXPAND.
  assign prev_idx = (cnt_q == '0) ? '0 : cnt_q - RND_W'(1);

  key_round_step u_step (
    .prev_key (rk_q[prev_idx]),
    .rcon     (RCON[cnt_q]),
    .next_key (step_key)
  );

  // FSM state, counter and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      key_ready_q  <= 1'b1;
      keys_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      key_ready_q  <= key_ready_d;
      keys_valid_q <= keys_valid_d;
    end
  end

  // Next-state: accept a key in IDLE/READY, then step once per cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    key_ready_d  = key_ready_q;
    keys_valid_d = keys_valid_q;
    load_key     = 1'b0;
    step_we      = 1'b0;
    clear_all    = 1'b0;
    unique case (state_q)
      IDLE, READY: begin
        if (key_valid && key_ready_q) begin
          load_key     = 1'b1;
          cnt_d        = RND_W'(1);
          state_d      = EXPAND;
          key_ready_d  = 1'b0;
          keys_valid_d = 1'b0;
        end
      end
      EXPAND: begin
        step_we = 1'b1;
        if (cnt_q == RND_W'(NR)) begin
          cnt_d        = '0;
          state_d      = READY;
          key_ready_d  = 1'b1;
          keys_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + RND_W'(1);
        end
      end
      default: begin
        cnt_d        = '0;
        state_d      = IDLE;
        key_ready_d  = 1'b1;
        keys_valid_d = 1'b0;
      end
    endcase
`ifdef AES_KEY_ZEROIZE_EN
    if (zeroize) begin
      load_key     = 1'b0;
      step_we      = 1'b0;
      clear_all    = 1'b1;
      cnt_d        = '0;
      state_d      = IDLE;
      key_ready_d  = 1'b1;
      keys_valid_d = 1'b0;
    end
`endif
  end

  // Round-key register file: key load at index 0, expansion at cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= int'(NR); i++) rk_q[i] <= '0;
    end else if (clear_all) begin
      for (int i = 0; i <= int'(NR); i++) rk_q[i] <= '0;
    end else begin
      if (load_key) rk_q[0] <= key_in;
      if (step_we)  rk_q[cnt_q] <= step_key;
    end
  end

  // Registered read port; out-of-range rounds read as zero.
  assign rd_key_d = (rd_round <= RND_W'(NR)) ? rk_q[rd_round] : '0;

  // Read data register, cleared together with storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_key_q <= '0;
    end else if (clear_all) begin
      rd_key_q <= '0;
    end else begin
      rd_key_q <= rd_key_d;
    end
  end

  assign key_ready  = key_ready_q;
  assign keys_valid = keys_valid_q;
  assign rd_key     = rd_key_q;

endmodule
